// File: rtl/dmem_pkg.sv
// Shared encodings and FSM states for the data-memory responder.
// Misalignment policy is selected with DMEM_MISALIGN_FAULT_EN.
package dmem_pkg;

  localparam logic [1:0] MEM_BYTE    = 2'd0;
  localparam logic [1:0] MEM_HALF    = 2'd1;
  localparam logic [1:0] MEM_WORD    = 2'd2;
  localparam logic [1:0] MEM_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  function automatic int width_bytes(logic [1:0] w);
    case (w)
      MEM_HALF: return 2;
      MEM_WORD: return 4;
      default:  return 1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store enables/data and load extract/extend.
// Purely combinational; address is already aligned by the caller.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int NB   = XLEN / 8,
  localparam int OFFW = $clog2(NB)
) (
  input  logic [1:0]      width_i,
  input  logic [OFFW-1:0] off_i,
  input  logic            sext_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rword_i,
  output logic [NB-1:0]   be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN-1:0] sh;
  logic [NB-1:0]   mask;
  logic            sbit;
  int              nbytes;
  int              nbits;

  always_comb begin
    nbytes  = width_bytes(width_i);
    nbits   = nbytes * 8;
    sh      = rword_i >> {off_i, 3'b000};
    wdata_o = wdata_i << {off_i, 3'b000};
    be_o    = '0;
    rdata_o = '0;
    mask    = '0;
    for (int i = 0; i < NB; i++) mask[i] = (i < nbytes);
    case (width_i)
      MEM_HALF: sbit = sh[15];
      MEM_WORD: sbit = sh[31];
      default:  sbit = sh[7];
    endcase
    if (width_i != MEM_ILLEGAL) begin
      be_o = mask << off_i;
      for (int i = 0; i < XLEN; i++)
        rdata_o[i] = (i < nbits) ? sh[i] : (sext_i & sbit);
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request, fixed-latency access, held response.
// Define DMEM_MISALIGN_FAULT_EN to fault misaligned half/word accesses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [1:0]      req_width,
  input  logic            req_sign_extend,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_fault
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int IDXW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [1:0]      width_q;
  logic            sext_q;
  logic            write_q;
  logic            ready_q;
  logic            valid_q;
  logic [XLEN-1:0] rdata_q;
  logic            fault_q;

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];

  logic [XLEN-1:0] amask;
  logic [XLEN-1:0] eaddr;
  logic [XLEN-1:0] widx;
  logic [IDXW-1:0] idx;
  logic            mis;
  logic            oob;
  logic            fault_d;
  logic            last;
  logic            do_wr;
  logic [NB-1:0]   be;
  logic [XLEN-1:0] wsh;
  logic [XLEN-1:0] ldata;
  logic [XLEN-1:0] rdata_d;

  assign amask = XLEN'(width_bytes(width_q) - 1);

`ifdef DMEM_MISALIGN_FAULT_EN
  assign eaddr = addr_q;
  assign mis   = |(addr_q & amask);
`else
  assign eaddr = addr_q & ~amask;
  assign mis   = 1'b0;
`endif

  assign widx    = eaddr >> OFFW;
  assign oob     = widx >= XLEN'(DEPTH_WORDS);
  assign idx     = widx[IDXW-1:0];
  assign fault_d = (width_q == MEM_ILLEGAL) | oob | mis;
  assign last    = (state_q == ST_ACCESS) && (cnt_q == 4'd0);
  assign do_wr   = reset_n & last & write_q & ~fault_d;
  assign rdata_d = (write_q | fault_d) ? '0 : ldata;

  dmem_lane_align #(.XLEN(XLEN)) u_align (
    .width_i (width_q),
    .off_i   (eaddr[OFFW-1:0]),
    .sext_i  (sext_q),
    .wdata_i (wdata_q),
    .rword_i (mem_q[idx]),
    .be_o    (be),
    .wdata_o (wsh),
    .rdata_o (ldata)
  );

  // Storage is never reset; only the final ACCESS cycle may write.
  always_ff @(posedge clock) begin
    if (do_wr) begin
      for (int b = 0; b < NB; b++)
        if (be[b]) mem_q[idx][b*8 +: 8] <= wsh[b*8 +: 8];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      width_q <= MEM_BYTE;
      sext_q  <= 1'b0;
      write_q <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (req_valid && ready_q) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            width_q <= req_width;
            sext_q  <= req_sign_extend;
            write_q <= req_write;
            cnt_q   <= 4'(LATENCY - 1);
            ready_q <= 1'b0;
            state_q <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cnt_q == 4'd0) begin
            rdata_q <= rdata_d;
            fault_q <= fault_d;
            valid_q <= 1'b1;
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign resp_fault = fault_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-array memory model.
// Honours DMEM_MISALIGN_FAULT_EN the same way as the design build.
module tb_dmem_responder;

  localparam int XLEN  = 32;
  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_width = 2'd0;
  logic        req_sign_extend = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_fault;

  int errs = 0;
  int checks = 0;

  logic [7:0] mb [DEPTH*4];

  dmem_responder #(
    .XLEN(XLEN), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_width       (req_width),
    .req_sign_extend (req_sign_extend),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_rdata      (resp_rdata),
    .resp_fault      (resp_fault)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Byte-oriented reference: size = 2^width bytes, little-endian.
  task automatic model(input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] w,
                       input logic sx, output logic [31:0] rd,
                       output logic flt);
    int size;
    longint a;
    logic [31:0] v;
    rd = '0;
    flt = (w == 2'd3);
    size = 1 << w;
    a = longint'(addr);
    if (!flt) begin
`ifdef DMEM_MISALIGN_FAULT_EN
      if (a % size != 0) flt = 1'b1;
`else
      a = a - (a % size);
`endif
      if (a / 4 >= DEPTH) flt = 1'b1;
    end
    if (flt) return;
    if (wr) begin
      for (int i = 0; i < size; i++) mb[int'(a) + i] = wdata[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = mb[int'(a) + i];
      if (sx && size < 4 && v[8*size-1])
        for (int i = 8*size; i < 32; i++) v[i] = 1'b1;
      rd = v;
    end
  endtask

  task automatic xact(input string tag, input logic wr,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [1:0] w, input logic sx, input int hold);
    logic [31:0] erd;
    logic        ef;
    int          n;
    model(wr, addr, wdata, w, sx, erd, ef);
    @(negedge clock);
    chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr = addr;
    req_wdata = wdata;
    req_width = w;
    req_sign_extend = sx;
    n = 0;
    do begin
      @(posedge clock);
      n++;
      @(negedge clock);
      req_valid = (hold > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      req_addr = $urandom;
      req_wdata = $urandom;
      req_width = 2'($urandom_range(0, 3));
      req_write = 1'($urandom_range(0, 1));
    end while (!resp_valid && n < 20);
    chk({tag, ".latency"}, 32'(n), 32'(LAT + 1));
    chk({tag, ".rdata"}, resp_rdata, erd);
    chk({tag, ".fault"}, 32'(resp_fault), 32'(ef));
    for (int k = 0; k < hold; k++) begin
      @(posedge clock);
      @(negedge clock);
      chk({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, ".hold_rdata"}, resp_rdata, erd);
      chk({tag, ".hold_fault"}, 32'(resp_fault), 32'(ef));
      chk({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
      req_valid = 1'($urandom_range(0, 1));
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    resp_ready = 1'b0;
    chk({tag, ".done_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, ".done_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  w;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst.req_ready", 32'(req_ready), 32'd1);
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.rdata", resp_rdata, 32'd0);
    chk("rst.fault", 32'(resp_fault), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < DEPTH; i++)
      xact("init", 1'b1, 32'(i * 4), $urandom, 2'd2, 1'b0, 0);

    xact("st_word", 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 0);
    xact("ld_word", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0);
    chk("ld_word.const", resp_rdata, 32'hDEADBEEF);
    xact("ld_b13_sx", 1'b0, 32'h13, 32'h0, 2'd0, 1'b1, 0);
    xact("ld_b13_zx", 1'b0, 32'h13, 32'h0, 2'd0, 1'b0, 0);
    xact("ld_h10_sx", 1'b0, 32'h10, 32'h0, 2'd1, 1'b1, 0);
    xact("st_b11", 1'b1, 32'h11, 32'h5A, 2'd0, 1'b0, 0);
    xact("ld_after_b", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0);
    xact("ld_oob", 1'b0, 32'(DEPTH * 4), 32'h0, 2'd2, 1'b0, 0);
    xact("ld_w3", 1'b0, 32'h10, 32'h0, 2'd3, 1'b0, 0);
    xact("st_mis", 1'b1, 32'h12, 32'hCAFEF00D, 2'd2, 1'b0, 0);
    xact("ld_10", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0);
    xact("ld_mis", 1'b0, 32'h12, 32'h0, 2'd2, 1'b0, 0);
    xact("hold5", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 5);

    // Reset lands on the first ACCESS cycle of a store.
    @(negedge clock);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr = 32'h20;
    req_wdata = 32'h11111111;
    req_width = 2'd2;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    reset_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    chk("abort.req_ready", 32'(req_ready), 32'd1);
    chk("abort.resp_valid", 32'(resp_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("abort.no_resp", 32'(resp_valid), 32'd0);
    end
    xact("abort.ld20", 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 0);

    for (int i = 0; i < 150; i++) begin
      a = 32'($urandom_range(0, DEPTH * 4 + 15));
      w = 2'($urandom_range(0, 3));
      xact("rand", 1'($urandom_range(0, 1)), a, $urandom, w,
           1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
